fp_mul_seq: RTL

Parametrised, iterative IEEE-754-style floating-point multiplier with valid/ready handshakes on both sides. It generalises the team's single-precision combinational multiplier to any exponent and fraction width. It adds round-to-nearest-even, special-value handling and exception flags. It sits between the operand-issue logic and the result writeback, one operation in flight at a time.

---
 rtl/fp_mul_seq_if.sv | 27 ++
 rtl/fp_mul_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for fp_mul_seq.
// master = operand issuer and result consumer, slave = multiplier.
interface fp_mul_seq_if #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
);
    localparam int unsigned W = 1 + EXP_W + FRAC_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/fp_mul_seq.sv
// Iterative floating-point multiplier: radix-2 shift-add mantissa product, round-to-nearest-even,
// flush-to-zero operands/results, canonical NaN and {invalid, overflow, underflow, inexact} flags.
module fp_mul_seq #(
    parameter int unsigned EXP_W  = 8,
    parameter int unsigned FRAC_W = 23
) (
    input  logic        clk,
    input  logic        rst,
    fp_mul_seq_if.slave bus
);
    localparam int unsigned W     = 1 + EXP_W + FRAC_W;
    localparam int unsigned M     = FRAC_W + 1;
    localparam int unsigned P     = 2 * M;
    localparam int unsigned EW    = EXP_W + 2;
    localparam int unsigned CNT_W = $clog2(M + 1);

    localparam logic [EW-1:0]     BIAS_U    = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [EW-1:0]     EXP_MAX_U = EW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0]  EXP_ONES  = '1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(M - 1);
    localparam logic [W-1:0]      QNAN      = {1'b0, EXP_ONES, 1'b1, {(FRAC_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMul, StRound, StDone} state_e;

    state_e             state_q, state_d;
    logic               sign_q, sign_d;
    logic [EXP_W-1:0]   ea_q, ea_d;
    logic [EXP_W-1:0]   eb_q, eb_d;
    logic [M-1:0]       ma_q, ma_d;
    logic [P-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]       result_q, result_d;
    logic [3:0]         flags_q, flags_d;

    // Operand fields and classes, seen directly on the bus at accept time
    logic               sign_a, sign_b, sign_p;
    logic [EXP_W-1:0]   exp_a, exp_b;
    logic [FRAC_W-1:0]  frac_a, frac_b;
    logic               a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
    logic               accept;

    assign sign_a = bus.a[W-1];
    assign sign_b = bus.b[W-1];
    assign exp_a  = bus.a[W-2 -: EXP_W];
    assign exp_b  = bus.b[W-2 -: EXP_W];
    assign frac_a = bus.a[FRAC_W-1:0];
    assign frac_b = bus.b[FRAC_W-1:0];
    assign sign_p = sign_a ^ sign_b;

    assign a_zero = (exp_a == '0);
    assign b_zero = (exp_b == '0);
    assign a_inf  = (exp_a == EXP_ONES) && (frac_a == '0);
    assign b_inf  = (exp_b == EXP_ONES) && (frac_b == '0);
    assign a_nan  = (exp_a == EXP_ONES) && (frac_a != '0);
    assign b_nan  = (exp_b == EXP_ONES) && (frac_b != '0);

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign accept        = bus.in_valid && bus.in_ready;

    // Multiplier lives in acc_q's low half and is consumed LSB first as the product shifts in
    logic [M:0]   step_sum;
    logic [P-1:0] acc_step;

    assign step_sum = {1'b0, acc_q[P-1:M]} + (acc_q[0] ? {1'b0, ma_q} : {(M + 1){1'b0}});
    assign acc_step = {step_sum, acc_q[M-1:1]};

    logic              norm, guard, sticky, round_up, carry;
    logic [P-1:0]      sh;
    logic [M-1:0]      mant;
    logic [M:0]        mant_r;
    logic [FRAC_W-1:0] frac_r;
    logic [EW-1:0]     exp_u;
    logic              ovf, unf;

    assign norm     = acc_q[P-1];
    assign sh       = norm ? acc_q : (acc_q << 1);
    assign mant     = sh[P-1 -: M];
    assign guard    = sh[M-1];
    assign sticky   = |sh[M-2:0];
    assign round_up = guard && (sticky || mant[0]);
    assign mant_r   = {1'b0, mant} + {{M{1'b0}}, round_up};
    assign carry    = mant_r[M];
    // On carry-out mant_r is 10..0, so its upper slice is the all-zero renormalised fraction
    assign frac_r   = carry ? mant_r[FRAC_W:1] : mant_r[FRAC_W-1:0];

    assign exp_u = EW'(ea_q) + EW'(eb_q) - BIAS_U + EW'(norm) + EW'(carry);
    assign ovf   = !exp_u[EW-1] && (exp_u >= EXP_MAX_U);
    assign unf   = exp_u[EW-1] || (exp_u == '0);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        flags_d  = flags_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sign_d = sign_p;
                    ea_d   = exp_a;
                    eb_d   = exp_b;
                    ma_d   = {1'b1, frac_a};
                    acc_d  = {{M{1'b0}}, 1'b1, frac_b};
                    cnt_d  = '0;
                    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
                        result_d = QNAN;
                        flags_d  = 4'b1000;
                        state_d  = StDone;
                    end else if (a_inf || b_inf) begin
                        result_d = {sign_p, EXP_ONES, {FRAC_W{1'b0}}};
                        flags_d  = 4'b0000;
                        state_d  = StDone;
                    end else if (a_zero || b_zero) begin
                        result_d = {sign_p, {(W - 1){1'b0}}};
                        flags_d  = 4'b0000;
                        state_d  = StDone;
                    end else begin
                        state_d = StMul;
                    end
                end
            end
            StMul: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                state_d = StDone;
                if (ovf) begin
                    result_d = {sign_q, EXP_ONES, {FRAC_W{1'b0}}};
                    flags_d  = 4'b0101;
                end else if (unf) begin
                    result_d = {sign_q, {(W - 1){1'b0}}};
                    flags_d  = 4'b0011;
                end else begin
                    result_d = {sign_q, exp_u[EXP_W-1:0], frac_r};
                    flags_d  = {3'b000, guard || sticky};
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            ea_q     <= '0;
            eb_q     <= '0;
            ma_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end
endmodule
